// File: rtl/vc_test_net_rr.sv
// vc_test_net_rr: N-port test network with per-input queues and per-output round-robin arbitration
module vc_test_net_rr #(
  parameter int p_num_ports = 4,
  parameter int p_queue_num_msgs = 4,
  parameter int p_payload_nbits = 8,
  parameter int p_opaque_nbits = 8,
  parameter int p_srcdest_nbits = 2,
  localparam int M = 2*p_srcdest_nbits + p_opaque_nbits + p_payload_nbits
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [p_num_ports-1:0]   in_val,
  output logic [p_num_ports-1:0]   in_rdy,
  input  logic [p_num_ports*M-1:0] in_msg,
  output logic [p_num_ports-1:0]   out_val,
  input  logic [p_num_ports-1:0]   out_rdy,
  output logic [p_num_ports*M-1:0] out_msg,
  output logic [p_num_ports-1:0]   err_bad_dest
);
  localparam int N = p_num_ports;
  localparam int Q = p_queue_num_msgs;
  localparam int S = p_srcdest_nbits;
  localparam int PW = $clog2(N);
  localparam int QW = $clog2(Q);
  localparam int CW = $clog2(Q + 1);
  logic [M-1:0] buf_q [N][Q];
  logic [QW-1:0] hd [N];
  logic [QW-1:0] tl [N];
  logic [CW-1:0] cnt [N];
  logic [PW-1:0] ptr [N];
  logic [PW-1:0] win [N];
  logic [M-1:0] head [N];
  logic [N-1:0] ne, bad, push, pop, fire;
  int idx;
  always_comb begin
    for (int i = 0; i < N; i++) begin
      head[i] = buf_q[i][hd[i]];
      ne[i] = cnt[i] != '0;
      bad[i] = ne[i] && (int'(head[i][M-1 -: S]) >= N);
      in_rdy[i] = cnt[i] != CW'(Q);
      push[i] = in_val[i] && in_rdy[i];
    end
  end
  always_comb begin
    out_val = '0;
    out_msg = '0;
    fire = '0;
    pop = bad;
    idx = 0;
    for (int j = 0; j < N; j++) begin
      win[j] = '0;
      for (int k = 0; k < N; k++) begin
        idx = (int'(ptr[j]) + k) % N;
        if (!out_val[j] && ne[idx] && int'(head[idx][M-1 -: S]) == j) begin
          out_val[j] = 1'b1;
          win[j] = PW'(idx);
          out_msg[j*M +: M] = head[idx];
        end
      end
      fire[j] = out_val[j] && out_rdy[j];
      if (fire[j]) pop[win[j]] = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_bad_dest <= '0;
      for (int i = 0; i < N; i++) begin
        hd[i] <= '0;
        tl[i] <= '0;
        cnt[i] <= '0;
        ptr[i] <= '0;
      end
    end else begin
      err_bad_dest <= err_bad_dest | bad;
      for (int i = 0; i < N; i++) begin
        if (push[i]) begin
          buf_q[i][tl[i]] <= in_msg[i*M +: M];
          tl[i] <= tl[i] == QW'(Q - 1) ? '0 : tl[i] + QW'(1);
        end
        if (pop[i]) hd[i] <= hd[i] == QW'(Q - 1) ? '0 : hd[i] + QW'(1);
        cnt[i] <= cnt[i] + CW'(push[i]) - CW'(pop[i]);
        if (fire[i]) ptr[i] <= win[i] == PW'(N - 1) ? '0 : win[i] + PW'(1);
      end
    end
  end
endmodule

// File: tb/tb_vc_test_net_rr.sv
// tb_vc_test_net_rr: randomized and directed self-checking bench for vc_test_net_rr
module tb_vc_test_net_rr;
  localparam int N = 4;
  localparam int Q = 4;
  localparam int M = 20;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic b_reset = 1'b0;
  always #5 clk = ~clk;
  logic [N-1:0] in_val, in_rdy, out_val, out_rdy, err;
  logic [N*M-1:0] in_msg, out_msg;
  logic [2:0] b_in_val, b_in_rdy, b_out_val, b_out_rdy, b_err;
  logic [3*M-1:0] b_in_msg, b_out_msg;
  vc_test_net_rr #(.p_num_ports(4), .p_queue_num_msgs(4), .p_payload_nbits(8), .p_opaque_nbits(8), .p_srcdest_nbits(2)) u_dut (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
    .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg), .err_bad_dest(err)
  );
  vc_test_net_rr #(.p_num_ports(3), .p_queue_num_msgs(4), .p_payload_nbits(8), .p_opaque_nbits(8), .p_srcdest_nbits(2)) u_dut3 (
    .clk(clk), .reset(b_reset), .in_val(b_in_val), .in_rdy(b_in_rdy), .in_msg(b_in_msg),
    .out_val(b_out_val), .out_rdy(b_out_rdy), .out_msg(b_out_msg), .err_bad_dest(b_err)
  );
  logic [M-1:0] mq [N][$];
  int mptr [N];
  logic [N-1:0] exp_val, exp_rdy;
  logic [N*M-1:0] exp_msg;
  int checks = 0;
  int failures = 0;
  function automatic int pick(int j);
    for (int k = 0; k < N; k++) begin
      int i;
      logic [M-1:0] h;
      i = (mptr[j] + k) % N;
      if (mq[i].size() > 0) begin
        h = mq[i][0];
        if (int'(h[M-1 -: 2]) == j) return i;
      end
    end
    return -1;
  endfunction
  task automatic tick();
    int w [N];
    logic [N-1:0] rp;
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        mq[i].delete();
        mptr[i] = 0;
      end
    end else begin
      for (int i = 0; i < N; i++) rp[i] = mq[i].size() < Q;
      for (int j = 0; j < N; j++) w[j] = pick(j);
      for (int j = 0; j < N; j++)
        if (w[j] >= 0 && out_rdy[j]) begin
          void'(mq[w[j]].pop_front());
          mptr[j] = (w[j] + 1) % N;
        end
      for (int i = 0; i < N; i++)
        if (in_val[i] && rp[i]) mq[i].push_back(in_msg[i*M +: M]);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic predict();
    exp_val = '0;
    exp_msg = '0;
    for (int j = 0; j < N; j++) begin
      int w;
      w = pick(j);
      if (w >= 0) begin
        exp_val[j] = 1'b1;
        exp_msg[j*M +: M] = mq[w][0];
      end
    end
    for (int i = 0; i < N; i++) exp_rdy[i] = mq[i].size() < Q;
  endtask
  task automatic do_reset();
    in_val = '0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask
  task automatic test_reset();
    in_val = '0;
    out_rdy = '1;
    in_msg = '0;
    b_in_val = '0;
    b_out_rdy = '1;
    b_in_msg = '0;
    reset = 1'b0;
    b_reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    b_reset = 1'b1;
    checks++;
    if (in_rdy !== 4'hf || out_val !== 4'h0 || err !== 4'h0 || out_msg !== '0) begin
      failures++;
      $display("FAIL reset: in_rdy=%h out_val=%h err=%h out_msg=%h, want f 0 0 0", in_rdy, out_val, err, out_msg);
    end
    checks++;
    if (b_in_rdy !== 3'b111 || b_out_val !== 3'b000 || b_err !== 3'b000) begin
      failures++;
      $display("FAIL reset3: in_rdy=%b out_val=%b err=%b, want 111 000 000", b_in_rdy, b_out_val, b_err);
    end
  endtask
  task automatic test_single();
    do_reset();
    out_rdy = '1;
    in_val = 4'b0001;
    in_msg[M-1:0] = 20'h400ce;
    tick();
    in_val = '0;
    checks++;
    if (out_val !== 4'b0010 || out_msg[M +: M] !== 20'h400ce) begin
      failures++;
      $display("FAIL single: out_val=%b out_msg1=%h, want 0010 400ce", out_val, out_msg[M +: M]);
    end
    tick();
    checks++;
    if (out_val !== 4'b0000 || in_rdy !== 4'hf) begin
      failures++;
      $display("FAIL single_drain: out_val=%b in_rdy=%h, want 0000 f", out_val, in_rdy);
    end
  endtask
  task automatic test_round_robin();
    int sel [3] = '{0, 2, 3};
    do_reset();
    out_rdy = '0;
    for (int k = 0; k < 3; k++) begin
      in_val = 4'b1101;
      for (int i = 0; i < N; i++) in_msg[i*M +: M] = {2'd0, 2'(i), 8'h00, 8'(k)};
      tick();
    end
    in_val = '0;
    out_rdy = '1;
    for (int c = 0; c < 9; c++) begin
      checks++;
      if (out_val[0] !== 1'b1 || out_msg[M-1:0] !== {2'd0, 2'(sel[c%3]), 8'h00, 8'(c/3)}) begin
        failures++;
        $display("FAIL rr cycle %0d: out_val0=%b msg=%h, want 1 %h", c, out_val[0], out_msg[M-1:0], {2'd0, 2'(sel[c%3]), 8'h00, 8'(c/3)});
      end
      tick();
    end
    checks++;
    if (out_val !== 4'h0) begin
      failures++;
      $display("FAIL rr_end: out_val=%b, want 0000", out_val);
    end
  endtask
  task automatic test_backpressure();
    int k;
    int got;
    logic send;
    do_reset();
    out_rdy = '0;
    in_val = 4'b0001;
    for (k = 0; k < 4; k++) begin
      in_msg[M-1:0] = {2'd1, 2'd0, 8'h00, 8'(k)};
      checks++;
      if (in_rdy[0] !== 1'b1) begin
        failures++;
        $display("FAIL bp_fill %0d: in_rdy0=%b, want 1", k, in_rdy[0]);
      end
      tick();
    end
    in_msg[M-1:0] = {2'd1, 2'd0, 8'h00, 8'd4};
    checks++;
    if (in_rdy[0] !== 1'b0) begin
      failures++;
      $display("FAIL bp_full: in_rdy0=%b, want 0", in_rdy[0]);
    end
    out_rdy[1] = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      if (out_val[1]) begin
        checks++;
        if (out_msg[M +: M] !== {2'd1, 2'd0, 8'h00, 8'(got)}) begin
          failures++;
          $display("FAIL bp_order %0d: msg=%h, want %h", got, out_msg[M +: M], {2'd1, 2'd0, 8'h00, 8'(got)});
        end
        got++;
      end
      send = in_val[0] && in_rdy[0];
      tick();
      if (send) begin
        k++;
        if (k < 6) in_msg[M-1:0] = {2'd1, 2'd0, 8'h00, 8'(k)};
        else in_val = '0;
      end
    end
    checks++;
    if (got !== 6) begin
      failures++;
      $display("FAIL bp_count: delivered=%0d, want 6", got);
    end
  endtask
  task automatic test_parallel();
    do_reset();
    out_rdy = '0;
    in_val = '1;
    for (int i = 0; i < N; i++) in_msg[i*M +: M] = {2'((i+1)%N), 2'(i), 8'h00, 8'(8'hA0 + i)};
    tick();
    in_val = '0;
    checks++;
    if (out_val !== 4'hf) begin
      failures++;
      $display("FAIL par_val: out_val=%b, want 1111", out_val);
    end
    for (int j = 0; j < N; j++) begin
      checks++;
      if (out_msg[j*M +: M] !== {2'(j), 2'((j+3)%N), 8'h00, 8'(8'hA0 + (j+3)%N)}) begin
        failures++;
        $display("FAIL par_msg %0d: msg=%h, want %h", j, out_msg[j*M +: M], {2'(j), 2'((j+3)%N), 8'h00, 8'(8'hA0 + (j+3)%N)});
      end
    end
    out_rdy = '1;
    tick();
    checks++;
    if (out_val !== 4'h0 || in_rdy !== 4'hf) begin
      failures++;
      $display("FAIL par_drain: out_val=%b in_rdy=%h, want 0000 f", out_val, in_rdy);
    end
  endtask
  task automatic test_reset_mid();
    do_reset();
    out_rdy = '0;
    in_val = 4'b0101;
    for (int i = 0; i < N; i++) in_msg[i*M +: M] = {2'd3, 2'(i), 8'h00, 8'h77};
    tick();
    tick();
    in_val = '0;
    checks++;
    if (out_val !== 4'b1000) begin
      failures++;
      $display("FAIL mid_pre: out_val=%b, want 1000", out_val);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if (out_val !== 4'h0 || in_rdy !== 4'hf || err !== 4'h0) begin
      failures++;
      $display("FAIL mid_reset: out_val=%b in_rdy=%h err=%h, want 0 f 0", out_val, in_rdy, err);
    end
    out_rdy = '1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (out_val !== 4'h0) begin
        failures++;
        $display("FAIL mid_stale %0d: out_val=%b, want 0000", c, out_val);
      end
    end
  endtask
  task automatic test_bad_dest();
    b_reset = 1'b0;
    b_out_rdy = '1;
    b_in_val = '0;
    tick();
    b_reset = 1'b1;
    b_in_val = 3'b010;
    b_in_msg[M +: M] = {2'd3, 2'd1, 8'h00, 8'hAA};
    tick();
    b_in_msg[M +: M] = {2'd2, 2'd1, 8'h00, 8'h55};
    checks++;
    if (b_out_val !== 3'b000 || b_err !== 3'b000) begin
      failures++;
      $display("FAIL bad_head: out_val=%b err=%b, want 000 000", b_out_val, b_err);
    end
    tick();
    b_in_val = '0;
    checks++;
    if (b_err !== 3'b010) begin
      failures++;
      $display("FAIL bad_flag: err=%b, want 010", b_err);
    end
    checks++;
    if (b_out_val !== 3'b100 || b_out_msg[2*M +: M] !== {2'd2, 2'd1, 8'h00, 8'h55}) begin
      failures++;
      $display("FAIL bad_next: out_val=%b msg2=%h, want 100 %h", b_out_val, b_out_msg[2*M +: M], {2'd2, 2'd1, 8'h00, 8'h55});
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (b_out_val !== 3'b000 || b_err !== 3'b010) begin
        failures++;
        $display("FAIL bad_sticky %0d: out_val=%b err=%b, want 000 010", c, b_out_val, b_err);
      end
    end
  endtask
  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      in_val = 4'($urandom);
      out_rdy = 4'($urandom);
      for (int i = 0; i < N; i++) in_msg[i*M +: M] = {2'($urandom_range(0, 3)), 2'(i), 16'($urandom)};
      tick();
      predict();
      checks++;
      if (out_val !== exp_val || out_msg !== exp_msg || in_rdy !== exp_rdy || err !== 4'h0) begin
        failures++;
        $display("FAIL random cycle %0d: val=%b msg=%h rdy=%b err=%b, want %b %h %b 0000", c, out_val, out_msg, in_rdy, err, exp_val, exp_msg, exp_rdy);
      end
    end
    in_val = '0;
  endtask
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_parallel();
    test_reset_mid();
    test_bad_dest();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
